matrix_input_parser: RTL and testbench

- Upstream neighbour of the matrix display stage: accepts ASCII bytes from the UART receiver and parses a matrix record "m n e0 e1 … e(m*n-1)".
- Validates dimensions and element range.
- Writes elements row-major into matrix storage starting at a base address, then reports the dimensions and a done/error status to the control FSM.

---
 rtl/matrix_input_parser_pkg.sv | 38 +++
 rtl/matrix_input_parser_if.sv | 29 ++
 rtl/matrix_input_parser_ascii_token_acc.sv | 48 ++++
 rtl/matrix_input_parser.sv | 179 +++++++++++++++++
 tb/tb_matrix_input_parser.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_input_parser_pkg.sv
// rtl/matrix_input_parser_pkg.sv - shared constants, states and error codes for the matrix input parser
package matrix_input_parser_pkg;

    localparam int MAX_DIM_DEF = 5;
    localparam int MAX_VAL_DEF = 9;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_M    = 3'd1,
        S_GET_N    = 3'd2,
        S_GET_ELEM = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_CHAR = 2'd1,
        ERR_DIM  = 2'd2,
        ERR_ELEM = 2'd3
    } err_code_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic logic is_delim(input logic [7:0] b);
        return (b == ASC_SPACE) || (b == ASC_CR) || (b == ASC_LF);
    endfunction

endpackage

// File: rtl/matrix_input_parser_if.sv
// rtl/matrix_input_parser_if.sv - control, byte-stream and storage-write signals of the parser
interface matrix_input_parser_if;
    logic        w_en_input;
    logic        w_in_abort;
    logic [7:0]  w_in_base_addr;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        w_in_wr_en;
    logic [7:0]  w_in_wr_addr;
    logic [31:0] w_in_wr_data;
    logic [31:0] w_in_m;
    logic [31:0] w_in_n;
    logic        w_in_busy;
    logic        w_in_done;
    logic        w_in_err;
    logic [1:0]  w_in_err_code;

    modport master (
        output w_en_input, w_in_abort, w_in_base_addr, rx_valid, rx_data,
        input  w_in_wr_en, w_in_wr_addr, w_in_wr_data, w_in_m, w_in_n,
               w_in_busy, w_in_done, w_in_err, w_in_err_code
    );

    modport slave (
        input  w_en_input, w_in_abort, w_in_base_addr, rx_valid, rx_data,
        output w_in_wr_en, w_in_wr_addr, w_in_wr_data, w_in_m, w_in_n,
               w_in_busy, w_in_done, w_in_err, w_in_err_code
    );
endinterface

// File: rtl/matrix_input_parser_ascii_token_acc.sv
// rtl/matrix_input_parser_ascii_token_acc.sv - byte classifier and saturating decimal token accumulator
module ascii_token_acc
    import matrix_input_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_tok_commit,
    output logic [7:0] o_tok_value,
    output logic       o_bad_char
);

    logic [7:0]  r_acc;
    logic        r_tok_active;
    logic        w_digit;
    logic        w_delim;
    logic [11:0] w_sum;
    logic [7:0]  w_acc_next;

    assign w_digit = is_digit(i_data);
    assign w_delim = is_delim(i_data);

    // Low nibble of an ASCII digit is its value; 255*10+9 still fits in 12 bits.
    assign w_sum      = ({4'd0, r_acc} * 12'd10) + {8'd0, i_data[3:0]};
    assign w_acc_next = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];

    assign o_tok_commit = i_valid && w_delim && r_tok_active;
    assign o_tok_value  = r_acc;
    assign o_bad_char   = i_valid && !w_digit && !w_delim;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc        <= 8'd0;
            r_tok_active <= 1'b0;
        end else if (i_valid) begin
            if (w_digit) begin
                r_acc        <= w_acc_next;
                r_tok_active <= 1'b1;
            end else if (o_tok_commit) begin
                r_acc        <= 8'd0;
                r_tok_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_input_parser.sv
// rtl/matrix_input_parser.sv - parses "m n e0 .. e(m*n-1)" from ASCII bytes and writes elements row-major
module matrix_input_parser
    import matrix_input_parser_pkg::*;
#(
    parameter int MAX_DIM = MAX_DIM_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input logic                  clk,
    input logic                  rst,
    matrix_input_parser_if.slave bus
);

    localparam int         TOT_W     = $clog2(MAX_DIM * MAX_DIM + 1);
    localparam logic [7:0] DIM_MAX_B = 8'(MAX_DIM);
    localparam logic [7:0] VAL_MAX_B = 8'(MAX_VAL);

    state_t          r_state;
    state_t          w_next;
    err_code_t       r_err_code;
    err_code_t       w_err_code;
    logic [7:0]      r_base;
    logic [7:0]      r_m;
    logic [7:0]      r_n;
    logic [7:0]      r_value;
    logic [TOT_W-1:0] r_total;
    logic [TOT_W-1:0] r_idx;
    logic            r_busy;
    logic            r_err;

    logic            w_start;
    logic            w_abort;
    logic            w_parsing;
    logic            w_commit;
    logic            w_bad;
    logic [7:0]      w_tok;
    logic            w_dim_ok;
    logic            w_last;
    logic [TOT_W-1:0] w_total;
    logic            w_wr_en;
    logic [7:0]      w_wr_addr;
    logic [31:0]     w_wr_data;
    logic            w_done;

    assign w_start   = (r_state == S_IDLE) && bus.w_en_input;
    assign w_abort   = bus.w_in_abort && (r_state != S_IDLE);
    assign w_parsing = (r_state == S_GET_M) || (r_state == S_GET_N) ||
                       (r_state == S_GET_ELEM) || (r_state == S_WRITE);
    assign w_dim_ok  = (w_tok != 8'd0) && (w_tok <= DIM_MAX_B);
    assign w_last    = (r_idx == (r_total - TOT_W'(1)));
    assign w_total   = TOT_W'(r_m) * TOT_W'(w_tok);

    // The accumulator keeps running through S_WRITE; it is held clear whenever no record is open.
    ascii_token_acc u_tok (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (!w_parsing || w_abort),
        .i_valid      (bus.rx_valid && w_parsing && !w_abort),
        .i_data       (bus.rx_data),
        .o_tok_commit (w_commit),
        .o_tok_value  (w_tok),
        .o_bad_char   (w_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_code = ERR_OK;
        case (r_state)
            S_IDLE: begin
                if (bus.w_en_input) w_next = S_GET_M;
            end
            S_GET_M, S_GET_N: begin
                if (w_bad) begin
                    w_next     = S_ERR;
                    w_err_code = ERR_CHAR;
                end else if (w_commit) begin
                    if (w_dim_ok) begin
                        w_next = (r_state == S_GET_M) ? S_GET_N : S_GET_ELEM;
                    end else begin
                        w_next     = S_ERR;
                        w_err_code = ERR_DIM;
                    end
                end
            end
            S_GET_ELEM: begin
                if (w_bad) begin
                    w_next     = S_ERR;
                    w_err_code = ERR_CHAR;
                end else if (w_commit) begin
                    if (w_tok > VAL_MAX_B) begin
                        w_next     = S_ERR;
                        w_err_code = ERR_ELEM;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (w_bad) begin
                    w_next     = S_ERR;
                    w_err_code = ERR_CHAR;
                end else begin
                    w_next = w_last ? S_DONE : S_GET_ELEM;
                end
            end
            S_DONE, S_ERR: w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        w_wr_en   = (r_state == S_WRITE) && !w_abort;
        w_wr_addr = 8'd0;
        w_wr_data = 32'd0;
        w_done    = ((r_state == S_DONE) || (r_state == S_ERR)) && !w_abort;
        if (w_wr_en) begin
            w_wr_addr = r_base + 8'(r_idx);
            w_wr_data = {24'd0, r_value};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= 8'd0;
            r_m        <= 8'd0;
            r_n        <= 8'd0;
            r_value    <= 8'd0;
            r_total    <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_OK;
        end else begin
            if (w_start) begin
                r_base     <= bus.w_in_base_addr;
                r_m        <= 8'd0;
                r_n        <= 8'd0;
                r_total    <= '0;
                r_idx      <= '0;
                r_busy     <= 1'b1;
                r_err      <= 1'b0;
                r_err_code <= ERR_OK;
            end
            if ((r_state == S_GET_M) && (w_next == S_GET_N)) r_m <= w_tok;
            if ((r_state == S_GET_N) && (w_next == S_GET_ELEM)) begin
                r_n     <= w_tok;
                r_total <= w_total;
                r_idx   <= '0;
            end
            if ((r_state == S_GET_ELEM) && (w_next == S_WRITE)) r_value <= w_tok;
            if (w_wr_en) r_idx <= r_idx + TOT_W'(1);
            // Error flag rises on the edge into S_ERR so it is already high alongside done.
            if ((w_next == S_ERR) && (r_state != S_ERR)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
            if ((r_state == S_DONE) || (r_state == S_ERR) || w_abort) r_busy <= 1'b0;
        end
    end

    assign bus.w_in_wr_en    = w_wr_en;
    assign bus.w_in_wr_addr  = w_wr_addr;
    assign bus.w_in_wr_data  = w_wr_data;
    assign bus.w_in_done     = w_done;
    assign bus.w_in_busy     = r_busy;
    assign bus.w_in_err      = r_err;
    assign bus.w_in_err_code = r_err_code;
    assign bus.w_in_m        = {24'd0, r_m};
    assign bus.w_in_n        = {24'd0, r_n};

endmodule

// File: tb/tb_matrix_input_parser.sv
// tb/tb_matrix_input_parser.sv - randomized and directed checks of matrix_input_parser against a token-level model
module tb_matrix_input_parser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_input_parser_if bus ();

    matrix_input_parser #(.MAX_DIM(5), .MAX_VAL(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_cnt;
    logic        done_err;
    logic [1:0]  done_code;
    logic [31:0] done_m;
    logic [31:0] done_n;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.w_in_wr_en) begin
                obs_addr.push_back(bus.w_in_wr_addr);
                obs_data.push_back(bus.w_in_wr_data);
            end
            if (bus.w_in_done) begin
                done_cnt++;
                done_err  = bus.w_in_err;
                done_code = bus.w_in_err_code;
                done_m    = bus.w_in_m;
                done_n    = bus.w_in_n;
            end
        end
    end

    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_done;
    int          exp_err;
    int          exp_code;
    int          exp_m;
    int          exp_n;

    // Reference: walk the text token by token; a record is m, n, then m*n values.
    task automatic model(input string s, input logic [7:0] base);
        int   tokens_seen;
        int   acc;
        bit   active;
        bit   fin;
        int   v;
        logic [7:0] c;
        tokens_seen = 0; acc = 0; active = 0; fin = 0;
        exp_addr.delete(); exp_data.delete();
        exp_done = 0; exp_err = 0; exp_code = 0; exp_m = 0; exp_n = 0;
        for (int i = 0; i < s.len() && !fin; i++) begin
            c = s[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                acc = acc * 10 + (c - 8'h30);
                if (acc > 255) acc = 255;
                active = 1;
            end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
                if (active) begin
                    v = acc; acc = 0; active = 0;
                    if (tokens_seen < 2) begin
                        if (v < 1 || v > 5) begin
                            exp_done = 1; exp_err = 1; exp_code = 2; fin = 1;
                        end else if (tokens_seen == 0) exp_m = v;
                        else exp_n = v;
                    end else if (v > 9) begin
                        exp_done = 1; exp_err = 1; exp_code = 3; fin = 1;
                    end else begin
                        exp_addr.push_back(base + 8'(tokens_seen - 2));
                        exp_data.push_back(32'(v));
                        if (tokens_seen - 1 == exp_m * exp_n) begin
                            exp_done = 1; fin = 1;
                        end
                    end
                    tokens_seen++;
                end
            end else begin
                exp_done = 1; exp_err = 1; exp_code = 1; fin = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] c, input bit en, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = c;
        bus.w_en_input = en;
        tick();
        bus.rx_valid   = 1'b0;
        bus.w_en_input = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start(input logic [7:0] base);
        obs_addr.delete(); obs_data.delete();
        done_cnt = 0;
        bus.w_in_base_addr = base;
        bus.w_en_input = 1'b1;
        tick();
        bus.w_en_input = 1'b0;
    endtask

    task automatic run_record(input string name, input string s, input logic [7:0] base,
                              input int en_at, input int max_gap);
        model(s, base);
        start(base);
        chk({name, ".busy_start"}, 32'(bus.w_in_busy), 1);
        for (int i = 0; i < s.len(); i++) begin
            if (i == en_at) bus.w_in_base_addr = base + 8'h40;
            send_byte(s[i], i == en_at, $urandom_range(0, max_gap));
        end
        for (int k = 0; k < 100 && done_cnt == 0; k++) tick();
        repeat (3) tick();
        chk({name, ".done"}, 32'(done_cnt), 32'(exp_done));
        chk({name, ".nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk($sformatf("%s.addr%0d", name, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s.data%0d", name, i), obs_data[i], exp_data[i]);
        end
        if (done_cnt > 0) begin
            chk({name, ".err"}, 32'(done_err), 32'(exp_err));
            chk({name, ".code"}, 32'(done_code), 32'(exp_code));
            if (exp_err == 0) begin
                chk({name, ".m"}, done_m, 32'(exp_m));
                chk({name, ".n"}, done_n, 32'(exp_n));
            end
        end
        chk({name, ".busy_end"}, 32'(bus.w_in_busy), 0);
    endtask

    function automatic string add_tok(input string s, input int v);
        string r;
        r = s;
        if ($urandom_range(0, 30) == 0) r = {r, $sformatf("%c", 8'(8'h41 + $urandom_range(0, 25)))};
        r = {r, $sformatf("%0d", v)};
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
            case ($urandom_range(0, 3))
                0:       r = {r, "\r"};
                1:       r = {r, "\n"};
                default: r = {r, " "};
            endcase
        end
        return r;
    endfunction

    function automatic int pick_dim();
        if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(6, 12);
        return $urandom_range(1, 5);
    endfunction

    function automatic string gen_record();
        string s;
        int    m, n, cnt;
        s = "";
        m = pick_dim();
        n = pick_dim();
        s = add_tok(s, m);
        s = add_tok(s, n);
        cnt = (m >= 1 && m <= 5 && n >= 1 && n <= 5) ? m * n : 3;
        for (int i = 0; i < cnt; i++)
            s = add_tok(s, ($urandom_range(0, 15) == 0) ? $urandom_range(10, 400) : $urandom_range(0, 9));
        return s;
    endfunction

    initial begin
        rst = 1'b1;
        bus.w_en_input = 1'b0; bus.w_in_abort = 1'b0; bus.w_in_base_addr = 8'h00;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        done_cnt = 0;
        repeat (3) tick();
        chk("rst.busy", 32'(bus.w_in_busy), 0);
        chk("rst.done", 32'(bus.w_in_done), 0);
        chk("rst.err", 32'(bus.w_in_err), 0);
        chk("rst.code", 32'(bus.w_in_err_code), 0);
        chk("rst.wr_en", 32'(bus.w_in_wr_en), 0);
        chk("rst.m", bus.w_in_m, 0);
        chk("rst.n", bus.w_in_n, 0);
        rst = 1'b0;
        tick();

        run_record("d_basic", "2 3 1 2 3 4 5 6\r\n", 8'h10, -1, 2);
        run_record("d_delims", "2  \r\n 2\r\n9 0\n 7  3 ", 8'h20, -1, 0);
        run_record("d_dim6", "6 2 ", 8'h00, -1, 1);
        run_record("d_dim0", "0 ", 8'h00, -1, 1);
        run_record("d_elem12", "1 2 4 12 ", 8'h00, -1, 1);
        run_record("d_char", "1 1 x", 8'h00, -1, 1);
        run_record("d_wrap", "1 3 1 2 3 ", 8'hFE, -1, 0);
        run_record("d_en_busy", "2 2 1 2 3 4 ", 8'h50, 6, 1);

        start(8'h30);
        send_byte("2", 0, 1); send_byte(" ", 0, 0); send_byte("2", 0, 1); send_byte(" ", 0, 0);
        send_byte("5", 0, 0); send_byte(" ", 0, 2);
        bus.w_in_abort = 1'b1;
        tick();
        bus.w_in_abort = 1'b0;
        repeat (5) tick();
        chk("abort.done", 32'(done_cnt), 0);
        chk("abort.busy", 32'(bus.w_in_busy), 0);
        chk("abort.nwr", 32'(obs_addr.size()), 1);
        if (obs_data.size() > 0) chk("abort.data0", obs_data[0], 5);
        run_record("after_abort", "2 1 8 9 ", 8'h60, -1, 1);

        start(8'h70);
        send_byte("3", 0, 0); send_byte(" ", 0, 0); send_byte("3", 0, 0); send_byte(" ", 0, 0);
        send_byte("7", 0, 0); send_byte(" ", 0, 1); send_byte("8", 0, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst.busy", 32'(bus.w_in_busy), 0);
        chk("mid_rst.done", 32'(bus.w_in_done), 0);
        chk("mid_rst.wr_en", 32'(bus.w_in_wr_en), 0);
        chk("mid_rst.addr", 32'(bus.w_in_wr_addr), 0);
        chk("mid_rst.data", bus.w_in_wr_data, 0);
        chk("mid_rst.m", bus.w_in_m, 0);
        chk("mid_rst.n", bus.w_in_n, 0);
        chk("mid_rst.err", 32'(bus.w_in_err), 0);
        rst = 1'b0;
        tick();
        run_record("after_rst", "1 2 0 9 ", 8'h80, -1, 1);

        for (int r = 0; r < 30; r++)
            run_record($sformatf("rnd%0d", r), gen_record(), 8'($urandom_range(0, 255)), -1, 2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
